// File: rtl/mat2_inv_core.sv
// 2x2 fixed-point matrix inverse: det, restoring reciprocal, scaled adjugate.
// Define INV_ROUND_EN for round-to-nearest shifts and a rounded reciprocal.
module mat2_inv_core #(
    parameter int DATA_W    = 64,
    parameter int FRAC_BITS = 32
) (
    input  logic                     I_sys_clk,
    input  logic                     I_sys_rstn,
    input  logic                     I_start,
    input  logic signed [DATA_W-1:0] I_A11,
    input  logic signed [DATA_W-1:0] I_A12,
    input  logic signed [DATA_W-1:0] I_A21,
    input  logic signed [DATA_W-1:0] I_A22,
    output logic [DATA_W-1:0]        O_A11_inv,
    output logic [DATA_W-1:0]        O_A12_inv,
    output logic [DATA_W-1:0]        O_A21_inv,
    output logic [DATA_W-1:0]        O_A22_inv,
    output logic                     O_inv_valid,
    output logic                     O_busy,
    output logic                     O_singular
);
    localparam int WW    = 2*DATA_W + 2;
    localparam int DIV_W = DATA_W + 1;
    localparam int CW    = $clog2(DATA_W + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MUL   = 3'd1;
    localparam logic [2:0] S_DET   = 3'd2;
    localparam logic [2:0] S_DIV   = 3'd3;
    localparam logic [2:0] S_SCALE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic signed [WW-1:0] MAXW  = {{(WW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [WW-1:0] MINW  = {{(WW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [WW-1:0] NMAXW = -MAXW;
    localparam logic [DATA_W-1:0]    MAXD  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DIV_W-1:0]     DVD0  = {{(DIV_W-1){1'b0}}, 1'b1} << (2*FRAC_BITS);
    localparam logic [CW-1:0]        CNT_LAST = CW'(DATA_W);
`ifdef INV_ROUND_EN
    localparam logic [WW-1:0]        HALF  = {{(WW-1){1'b0}}, 1'b1} << (FRAC_BITS-1);
`endif

    function automatic logic signed [WW-1:0] shr(input logic signed [WW-1:0] v);
`ifdef INV_ROUND_EN
        logic [WW-1:0] mag;
        mag = v[WW-1] ? -v : v;
        mag = (mag + HALF) >> FRAC_BITS;
        return v[WW-1] ? -mag : mag;
`else
        return v >>> FRAC_BITS;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] sat(input logic signed [WW-1:0] v);
        if (v > MAXW)      return MAXW[DATA_W-1:0];
        else if (v < MINW) return MINW[DATA_W-1:0];
        else               return v[DATA_W-1:0];
    endfunction

    logic [2:0]                state;
    logic [CW-1:0]             cnt;
    logic signed [DATA_W-1:0]  a11, a12, a21, a22;
    logic signed [2*DATA_W-1:0] p0, p1;
    logic [DATA_W-1:0]         rem, dvs;
    logic [DIV_W-1:0]          dvd, quo;
    logic                      sign_det;
    logic [DATA_W-1:0]         res0, res1, res2;

    logic signed [WW-1:0]      det_w, det_sh, prod, sc_sh, sc_neg;
    logic signed [DATA_W-1:0]  det_sat;
    logic [DATA_W-1:0]         det_abs, rem_nx, r_val, sc_out;
    logic [DATA_W:0]           rem_sh;
    logic                      div_ge;
    logic signed [DATA_W:0]    adj;

    assign O_busy = (state != S_IDLE);

    always_comb begin
        det_w  = {{2{p0[2*DATA_W-1]}}, p0} - {{2{p1[2*DATA_W-1]}}, p1};
        det_sh = shr(det_w);
        // Symmetric clamp keeps |det| representable for the divider.
        if (det_sh > MAXW)       det_sat = MAXW[DATA_W-1:0];
        else if (det_sh < NMAXW) det_sat = NMAXW[DATA_W-1:0];
        else                     det_sat = det_sh[DATA_W-1:0];
        det_abs = det_sat[DATA_W-1] ? -det_sat : det_sat;

        rem_sh = {rem, dvd[DIV_W-1]};
        div_ge = (rem_sh >= {1'b0, dvs});
        rem_nx = div_ge ? rem_sh[DATA_W-1:0] - dvs : rem_sh[DATA_W-1:0];

        r_val = (quo > {1'b0, MAXD}) ? MAXD : quo[DATA_W-1:0];
        case (cnt[1:0])
            2'd0:    adj = {a22[DATA_W-1], a22};
            2'd1:    adj = -{a12[DATA_W-1], a12};
            2'd2:    adj = -{a21[DATA_W-1], a21};
            default: adj = {a11[DATA_W-1], a11};
        endcase
        prod   = {{(WW-DATA_W-1){adj[DATA_W]}}, adj} * {{(WW-DATA_W){1'b0}}, r_val};
        sc_sh  = shr(prod);
        sc_neg = sign_det ? -sc_sh : sc_sh;
        sc_out = sat(sc_neg);
    end

    always_ff @(posedge I_sys_clk) begin
        if (!I_sys_rstn) begin
            state <= S_IDLE;  cnt <= '0;
            a11 <= '0; a12 <= '0; a21 <= '0; a22 <= '0;
            p0 <= '0; p1 <= '0;
            rem <= '0; dvs <= '0; dvd <= '0; quo <= '0; sign_det <= 1'b0;
            res0 <= '0; res1 <= '0; res2 <= '0;
            O_A11_inv <= '0; O_A12_inv <= '0; O_A21_inv <= '0; O_A22_inv <= '0;
            O_inv_valid <= 1'b0; O_singular <= 1'b0;
        end else begin
            O_inv_valid <= 1'b0;
            case (state)
                S_IDLE: if (I_start) begin
                    a11 <= I_A11; a12 <= I_A12; a21 <= I_A21; a22 <= I_A22;
                    state <= S_MUL;
                end
                S_MUL: begin
                    p0 <= $signed({{DATA_W{a11[DATA_W-1]}}, a11}) * $signed({{DATA_W{a22[DATA_W-1]}}, a22});
                    p1 <= $signed({{DATA_W{a12[DATA_W-1]}}, a12}) * $signed({{DATA_W{a21[DATA_W-1]}}, a21});
                    state <= S_DET;
                end
                S_DET: if (det_sat == '0) begin
                    O_A11_inv <= '0; O_A12_inv <= '0; O_A21_inv <= '0; O_A22_inv <= '0;
                    O_singular <= 1'b1; O_inv_valid <= 1'b1;
                    state <= S_DONE;
                end else begin
                    sign_det <= det_sat[DATA_W-1];
                    dvs <= det_abs;
`ifdef INV_ROUND_EN
                    dvd <= DVD0 + {1'b0, det_abs >> 1};
`else
                    dvd <= DVD0;
`endif
                    rem <= '0; quo <= '0; cnt <= '0;
                    state <= S_DIV;
                end
                S_DIV: begin
                    rem <= rem_nx;
                    dvd <= dvd << 1;
                    quo <= {quo[DIV_W-2:0], div_ge};
                    if (cnt == CNT_LAST) begin
                        cnt <= '0; state <= S_SCALE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SCALE: begin
                    cnt <= cnt + 1'b1;
                    case (cnt[1:0])
                        2'd0: res0 <= sc_out;
                        2'd1: res1 <= sc_out;
                        2'd2: res2 <= sc_out;
                        default: begin
                            O_A11_inv <= res0; O_A12_inv <= res1;
                            O_A21_inv <= res2; O_A22_inv <= sc_out;
                            O_singular <= 1'b0; O_inv_valid <= 1'b1;
                            state <= S_DONE;
                        end
                    endcase
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/mat2_inv_core.md
Name: mat2_inv_core

Overview:
- Sequential 2x2 matrix-inverse engine that sits directly upstream of the A-inverse hold/latch stage.
- Accepts four signed fixed-point elements A11..A22 on a start pulse and computes det = A11*A22 - A12*A21.
- Forms 1/det with a shared restoring divider, then scales the adjugate to produce A_inv.
- Results are held on the outputs until the next computation completes, so the downstream stage can sample them at its fixed counter slot.

Parameters:
- DATA_W, 64, element width; two's-complement signed.
- FRAC_BITS, 32, fractional bits (Q32.32 at defaults). 1.0 = 0x0000_0001_0000_0000.

Ports:
- I_sys_clk  input  1  system clock; all logic on its rising edge.
- I_sys_rstn  input  1  reset, synchronous, active-low.
- I_start  input  1  one-cycle request; sampled only in IDLE.
- I_A11 / I_A12 / I_A21 / I_A22  input  DATA_W each  matrix elements; captured on accepted start.
- O_A11_inv / O_A12_inv / O_A21_inv / O_A22_inv  output  DATA_W each  inverse elements; held until next DONE.
- O_inv_valid  output  1  one-cycle pulse when new results are on the outputs.
- O_busy  output  1  high from the cycle after start acceptance until the DONE cycle, inclusive.
- O_singular  output  1  set with O_inv_valid when det == 0; held with the results.

Behaviour:
- Reset (I_sys_rstn low at a clock edge):
  - All outputs go to 0.
  - FSM goes to IDLE.
  - Divider and internal registers are cleared.
  - Reset mid-computation aborts it; no valid pulse follows.
- FSM states: IDLE -> MUL -> DET -> DIV -> SCALE -> DONE -> IDLE.
- IDLE: when I_start = 1, register the inputs and go to MUL. I_start in any other state is ignored (no queueing).
- MUL, 1 cycle: form the full-width products A11*A22 and A12*A21 (2*DATA_W bits, signed).
- DET, 1 cycle:
  - Compute det_full = difference of the products (2*DATA_W+1 bits), then det = det_full >>> FRAC_BITS.
  - If det does not fit in DATA_W bits, saturate to ±(2^(DATA_W-1)-1) in that direction.
  - If det == 0, go straight to DONE with all results 0 and singular = 1.
- DIV, DATA_W+1 cycles:
  - Unsigned restoring division computes R = floor(2^(2*FRAC_BITS) / |det|), one quotient bit per cycle, MSB first.
  - If R > 2^(DATA_W-1)-1, saturate R to that value.
  - Record sign_det.
- SCALE, 4 cycles, one shared DATA_W x DATA_W multiplier:
  - Adjugate order: A22, -A12, -A21, A11.
  - Each element: p = adj * R, then >>> FRAC_BITS (truncate toward -inf), then negate if sign_det = 1, then saturate to DATA_W signed.
  - Negating the most-negative value saturates to the most-positive value.
- DONE, 1 cycle: load the four output registers and O_singular, pulse O_inv_valid, return to IDLE.
- Latency (start sampled at cycle 0):
  - MUL at 1, DET at 2, DIV at 3..67, SCALE at 68..71.
  - O_inv_valid is high at cycle 72 and the outputs update on that same edge.
  - Singular case: O_inv_valid at cycle 3.
  - Worst-case latency of 72 cycles fits within the downstream 103-cycle sampling slot.
- Back-to-back: a start in the DONE cycle is ignored. The earliest next accepted start is the cycle after DONE.

Optional Feature:
- Macro INV_ROUND_EN.
- Defined:
  - The DET and SCALE right-shifts round to nearest: add 2^(FRAC_BITS-1) before the shift, ties away from zero on the magnitude.
  - The divider adds |det|>>1 to the dividend for a rounded reciprocal.
  - Latency is unchanged.
- Undefined: truncation exactly as in Behaviour.

Test Plan:
- Identity: A11 = A22 = 0x0000_0001_0000_0000, A12 = A21 = 0, start -> at cycle 72 O_inv_valid = 1, outputs equal the identity, O_singular = 0.
- Diagonal [[2,0],[0,4]] -> O_A11_inv = 0x0000_0000_8000_0000, O_A22_inv = 0x0000_0000_4000_0000, off-diagonals 0.
- [[1,2],[3,4]] (det = -2) -> outputs [[-2.0, 1.0],[1.5, -0.5]]:
  - O_A11_inv = 0xFFFF_FFFE_0000_0000
  - O_A21_inv = 0x0000_0001_8000_0000
  - O_A22_inv = 0xFFFF_FFFF_8000_0000
- Singular [[1,2],[2,4]] -> O_inv_valid at cycle 3, all outputs 0, O_singular = 1. A following identity start clears O_singular.
- Start pulses at cycles 10 and 40 while busy -> exactly one valid pulse. Outputs remain held for 500 idle cycles afterward.
- Reset asserted at cycle 30 of DIV -> all outputs 0 on the next edge, no valid pulse. A new start then completes normally in 72 cycles.
